// File: rtl/regfile_param.sv
// Parametrised register file: one byte-masked write port, two independent
// read ports, optional write-to-read bypass, optional registered reads,
// optional hardwired zero register and a sequenced whole-array clear.
module regfile_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int REG_READ = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_mask,
  input  logic [ADDR_W-1:0]    rd_addr1,
  input  logic [ADDR_W-1:0]    rd_addr2,
  input  logic                 clr_req,
  output logic [WIDTH-1:0]     rd_data1,
  output logic [WIDTH-1:0]     rd_data2,
  output logic                 busy
);

  localparam int NBYTES = WIDTH / 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_next;

  logic [WIDTH-1:0]    r_mem [DEPTH];

  logic                w_busy;
  logic                w_wr_drop;
  logic                w_wr_ok;
  logic [WIDTH-1:0]    w_wr_old;
  logic [WIDTH-1:0]    w_wr_merged;

  logic [ADDR_W-1:0]   w_rd_addr [2];
  logic [WIDTH-1:0]    w_rd_val  [2];
  logic [WIDTH-1:0]    w_rd_out  [2];

  assign w_busy    = (r_state == S_CLEAR);
  // Writes to address 0 vanish when it is the hardwired zero register.
  assign w_wr_drop = (ZERO_REG != 0) && (wr_addr == '0);
  // A write only lands when no clear sequence is running.
  assign w_wr_ok   = en && !w_busy && !w_wr_drop;
  assign w_wr_old  = r_mem[wr_addr];

  // Byte-wise merge of the incoming data over the current register contents.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign w_wr_merged[8*gi +: 8] = wr_mask[gi] ? wr_data[8*gi +: 8]
                                                  : w_wr_old[8*gi +: 8];
    end
  endgenerate

  // Clear sequencer next-state: walk the pointer from 0 to DEPTH-1 once.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_next = S_CLEAR;
          w_ptr_next   = '0;
        end
      end
      S_CLEAR: begin
        w_ptr_next = r_ptr + 1'b1;
        if (r_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_ptr_next   = '0;
      end
    endcase
  end

  // Clear sequencer state register; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Storage update: reset zeroes everything, clearing owns the array while
  // busy, otherwise the merged write data lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_busy) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= w_wr_merged;
    end
  end

  assign w_rd_addr[0] = rd_addr1;
  assign w_rd_addr[1] = rd_addr2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Architectural read value: zero register, then bypass, then storage.
      always_comb begin
        w_rd_val[gi] = r_mem[w_rd_addr[gi]];
        if ((ZERO_REG != 0) && (w_rd_addr[gi] == '0)) begin
          w_rd_val[gi] = '0;
        end else if ((BYPASS != 0) && w_wr_ok && (w_rd_addr[gi] == wr_addr)) begin
          w_rd_val[gi] = w_wr_merged;
        end
      end

      if (REG_READ != 0) begin : g_reg
        logic [WIDTH-1:0] r_rd_data;
        // Registered read: capture the read value at the edge.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_rd_data <= '0;
          end else begin
            r_rd_data <= w_rd_val[gi];
          end
        end
        assign w_rd_out[gi] = r_rd_data;
      end else begin : g_comb
        assign w_rd_out[gi] = w_rd_val[gi];
      end
    end
  endgenerate

  assign rd_data1 = w_rd_out[0];
  assign rd_data2 = w_rd_out[1];
  assign busy     = w_busy;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param. Three instances share one stimulus
// stream: default config, no-bypass config, and zero-register + registered
// reads. A behavioural model predicts every read and the busy flag.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic        clr_req;

  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
  logic        a_busy, b_busy, c_busy;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;

  regfile_param u_dut (
    .clk(clk), .rst(rst), .en(en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .clr_req(clr_req), .rd_data1(a_rd1), .rd_data2(a_rd2), .busy(a_busy)
  );

  regfile_param #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .en(en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .clr_req(clr_req), .rd_data1(b_rd1), .rd_data2(b_rd2), .busy(b_busy)
  );

  regfile_param #(.ZERO_REG(1), .REG_READ(1)) u_zr (
    .clk(clk), .rst(rst), .en(en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .clr_req(clr_req), .rd_data1(c_rd1), .rd_data2(c_rd2), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    int          cyc;
    logic [15:0] a1, a2, b1, b2;
    bit          busy;
  } comb_exp_t;

  typedef struct {
    bit          chk;
    int          cyc;
    logic [15:0] c1, c2;
  } reg_exp_t;

  comb_exp_t q_comb[$];
  reg_exp_t  q_reg[$];

  // Reference model: plain register arrays plus a clear progress index.
  logic [15:0] m_mem  [16];
  logic [15:0] m_zmem [16];
  bit          m_valid    = 1'b0;
  bit          m_clearing = 1'b0;
  int          m_idx      = 0;

  function automatic logic [15:0] merge(input logic [15:0] old_v,
                                        input logic [15:0] new_v,
                                        input logic [1:0]  m);
    logic [15:0] r;
    r = old_v;
    if (m[0]) r[7:0]  = new_v[7:0];
    if (m[1]) r[15:8] = new_v[15:8];
    return r;
  endfunction

  task automatic check(input string name, input int cyc,
                       input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // One stimulus cycle: drive, predict, push, advance the model.
  task automatic cyc(input bit r, input bit e, input logic [3:0] wa,
                     input logic [15:0] wd, input logic [1:0] wm,
                     input logic [3:0] a1, input logic [3:0] a2, input bit c);
    comb_exp_t ce;
    reg_exp_t  re;
    logic [15:0] mg, mgz;
    bit wok, wokz;
    @(negedge clk);
    rst = r; en = e; wr_addr = wa; wr_data = wd; wr_mask = wm;
    rd_addr1 = a1; rd_addr2 = a2; clr_req = c;
    #1;
    wok  = !r && e && !m_clearing;
    wokz = wok && (wa != 4'd0);
    mg   = merge(m_mem[wa], wd, wm);
    mgz  = merge(m_zmem[wa], wd, wm);

    ce.chk  = m_valid;
    ce.cyc  = ncyc;
    ce.busy = m_clearing;
    ce.b1   = m_mem[a1];
    ce.b2   = m_mem[a2];
    ce.a1   = (wok && a1 == wa) ? mg : m_mem[a1];
    ce.a2   = (wok && a2 == wa) ? mg : m_mem[a2];
    q_comb.push_back(ce);

    re.chk = m_valid || r;
    re.cyc = ncyc + 1;
    if (r) begin
      re.c1 = 16'h0000;
      re.c2 = 16'h0000;
    end else begin
      re.c1 = (a1 == 4'd0) ? 16'h0000 : ((wokz && a1 == wa) ? mgz : m_zmem[a1]);
      re.c2 = (a2 == 4'd0) ? 16'h0000 : ((wokz && a2 == wa) ? mgz : m_zmem[a2]);
    end
    q_reg.push_back(re);

    if (r) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[i]  = 16'h0000;
        m_zmem[i] = 16'h0000;
      end
      m_clearing = 1'b0;
      m_idx      = 0;
      m_valid    = 1'b1;
    end else if (m_clearing) begin
      m_mem[m_idx]  = 16'h0000;
      m_zmem[m_idx] = 16'h0000;
      m_idx++;
      if (m_idx == 16) m_clearing = 1'b0;
    end else begin
      if (wok)  m_mem[wa]  = mg;
      if (wokz) m_zmem[wa] = mgz;
      if (c) begin
        m_clearing = 1'b1;
        m_idx      = 0;
      end
    end
    ncyc++;
  endtask

  task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
    cyc(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, a1, a2, 1'b0);
  endtask

  task automatic wr(input logic [3:0] wa, input logic [15:0] wd, input logic [1:0] wm);
    cyc(1'b0, 1'b1, wa, wd, wm, wa, wa + 4'd1, 1'b0);
  endtask

  // Monitor: sample outputs mid-cycle, pop expectations and compare.
  initial begin
    comb_exp_t ce;
    reg_exp_t  re;
    forever begin
      @(negedge clk);
      #2;
      if (q_comb.size() > 0) begin
        ce = q_comb.pop_front();
        if (ce.chk) begin
          check("dflt_rd1", ce.cyc, a_rd1, ce.a1);
          check("dflt_rd2", ce.cyc, a_rd2, ce.a2);
          check("nobyp_rd1", ce.cyc, b_rd1, ce.b1);
          check("nobyp_rd2", ce.cyc, b_rd2, ce.b2);
          check("dflt_busy", ce.cyc, {15'd0, a_busy}, {15'd0, ce.busy});
          check("nobyp_busy", ce.cyc, {15'd0, b_busy}, {15'd0, ce.busy});
          check("zr_busy", ce.cyc, {15'd0, c_busy}, {15'd0, ce.busy});
        end
      end
      if (q_reg.size() >= 2) begin
        re = q_reg.pop_front();
        if (re.chk) begin
          check("zr_rd1", re.cyc, c_rd1, re.c1);
          check("zr_rd2", re.cyc, c_rd2, re.c2);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized stream.
  initial begin
    rst = 1'b1; en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_addr1 = '0; rd_addr2 = '0; clr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_mem[i]  = 16'h0000;
      m_zmem[i] = 16'h0000;
    end

    cyc(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 4'd1, 4'd2, 1'b0);

    // Basic write then read on both ports
    wr(4'd1, 16'hB274, 2'b11);
    idle(4'd1, 4'd1);
    idle(4'd5, 4'd0);

    // Byte mask and empty mask
    wr(4'd2, 16'hEA7C, 2'b11);
    wr(4'd2, 16'h1234, 2'b01);
    idle(4'd2, 4'd2);
    wr(4'd2, 16'h5678, 2'b00);
    idle(4'd2, 4'd1);

    // Same-cycle bypass
    cyc(1'b0, 1'b1, 4'd3, 16'h8277, 2'b11, 4'd3, 4'd3, 1'b0);
    idle(4'd3, 4'd3);

    // Fill with all ones, then clear with probes and a dropped write
    for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF, 2'b11);
    cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 4'd4, 4'd5, 1'b1);
    for (int i = 0; i < 18; i++) begin
      if (i == 7)
        cyc(1'b0, 1'b1, 4'd9, 16'h1111, 2'b11, 4'd9, 4'd5, 1'b1);
      else
        idle(4'd4, 4'd5);
    end
    for (int i = 0; i < 16; i += 2) idle(4'(i), 4'(i + 1));

    // Reset mid-clear, then a fresh clear is accepted
    for (int i = 0; i < 16; i++) wr(4'(i), 16'hA5C3, 2'b11);
    cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd8, 1'b1);
    for (int i = 0; i < 3; i++) idle(4'd2, 4'd3);
    cyc(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 4'd2, 4'd9, 1'b0);
    for (int i = 0; i < 16; i += 2) idle(4'(i), 4'(i + 1));
    wr(4'd6, 16'h3C3C, 2'b11);
    cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 4'd6, 4'd0, 1'b1);
    for (int i = 0; i < 18; i++) idle(4'd6, 4'd15);

    // Write and clear in the same idle cycle
    cyc(1'b0, 1'b1, 4'd5, 16'hAAAA, 2'b11, 4'd5, 4'd5, 1'b1);
    for (int i = 0; i < 18; i++) idle(4'd5, 4'd0);

    // Zero register and registered-read latency
    cyc(1'b0, 1'b1, 4'd0, 16'hBEEF, 2'b11, 4'd0, 4'd0, 1'b0);
    idle(4'd0, 4'd0);
    cyc(1'b0, 1'b1, 4'd7, 16'h0F0F, 2'b11, 4'd0, 4'd7, 1'b0);
    idle(4'd0, 4'd7);
    idle(4'd7, 4'd7);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 1) == 1),
          4'($urandom_range(0, 15)),
          16'($urandom),
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 39) == 0));
    end
    idle(4'd0, 4'd1);

    // Let the monitor drain everything that was issued
    repeat (3) @(negedge clk);
    #4;
    check("drain_comb", ncyc, 16'(q_comb.size()), 16'd0);
    check("drain_reg", ncyc, 16'(q_reg.size()), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the team's 16x16 two-read/one-write register file, generalised in width and depth.
- Adds byte-masked writes, optional write-to-read bypass, optional registered read ports, optional hardwired zero register, and a sequenced whole-array clear with a busy flag.
- Sits as the architectural register store beside the datapath; one write port, two independent read ports.

Parameters:
- WIDTH, 16: data width in bits; must be a multiple of 8.
- DEPTH, 16: number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH): address width; derived, not overridden.
- REG_READ, 0: 0 = combinational reads; 1 = one-cycle registered reads.
- BYPASS, 1: 1 = a read of the address being written in the same cycle returns the new (merged) data.
- ZERO_REG, 0: 1 = address 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- wr_mask  in  WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- clr_req  in  1  single-cycle pulse requesting a full-array clear.
- rd_data1  out  WIDTH  read port 1 data.
- rd_data2  out  WIDTH  read port 2 data.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (rst=1 at an edge):
  - All DEPTH registers become 0.
  - FSM goes to IDLE; clear pointer goes to 0; busy=0.
  - With REG_READ=1, rd_data1 and rd_data2 become 0.
  - rst overrides clr_req and en in the same cycle.
  - A reset mid-clear aborts the sequence; the array is fully zeroed by the reset itself.
- Write:
  - Occurs at an edge when en=1, busy=0 and rst=0.
  - For each byte i with wr_mask[i]=1, mem[wr_addr] byte i takes wr_data byte i. Unmasked bytes are unchanged.
  - wr_mask=0 is a no-op.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (REG_READ=0):
  - rd_dataN = mem[rd_addrN] combinationally; new data is visible the cycle after the write edge.
  - BYPASS=1: if en=1, busy=0, rd_addrN==wr_addr and the write is not dropped, rd_dataN = merge(mem[wr_addr], wr_data, wr_mask) in the same cycle.
  - ZERO_REG=1: rd_addrN=0 always returns 0.
- Read (REG_READ=1):
  - The value defined for REG_READ=0 (including bypass) is captured at the edge and presented the following cycle.
  - Latency is 1 cycle.
- Both read ports are fully independent; identical addresses return identical data.
- Clear FSM:
  - States: IDLE, CLEAR.
  - IDLE → CLEAR at an edge with clr_req=1; pointer=0; busy=1 from the next cycle.
  - In CLEAR, at each edge mem[ptr] ← 0 and ptr ← ptr+1. When ptr==DEPTH-1, that register is cleared and the FSM returns to IDLE; busy=0 from the following cycle.
  - busy is high for exactly DEPTH cycles.
  - clr_req while busy=1 is ignored, with no restart.
  - en while busy=1 is dropped; the write is lost and there is no bypass.
  - Reads during CLEAR return current contents: addresses below ptr read 0, others read old data.
  - clr_req and en in the same IDLE cycle: the write commits first, then the clear sequence erases it.
- Pointer arithmetic is ADDR_W bits; the terminal test uses DEPTH-1, so there is no wrap beyond the sequence.

Test Plan:
- Reset, then en=1, wr_addr=1, wr_data=16'hB274, wr_mask=2'b11; next cycle rd_addr1=1, rd_addr2=1 → both read 16'hB274. Any other address reads 16'h0000.
- Mask: reg2=16'hEA7C, then write wr_addr=2, wr_data=16'h1234, wr_mask=2'b01 → reg2 reads 16'hEA34. A further write with wr_mask=2'b00 leaves reg2 at 16'hEA34.
- Bypass (REG_READ=0, BYPASS=1): en=1, wr_addr=3, wr_data=16'h8277, rd_addr1=3 in the same cycle → rd_data1=16'h8277 before the edge. With BYPASS=0, rd_data1 shows the old value 16'h0000 that cycle.
- Clear: fill regs 0..15 with 16'hFFFF, pulse clr_req → busy high for exactly 16 cycles.
  - Mid-sequence (after 5 clear edges), addr 4 reads 0 and addr 5 reads 16'hFFFF.
  - An en write to addr 9 during busy is dropped.
  - After busy falls, every register reads 0.
- Reset mid-clear after 3 clear edges → busy=0 next cycle, all registers 0. A subsequent clr_req is accepted normally.
- ZERO_REG=1, REG_READ=1: write 16'hBEEF to addr 0 → reads 0. Write 16'h0F0F to addr 7 with rd_addr2=7 → rd_data2 changes exactly one cycle after the read is sampled (bypassed value captured at the write edge).
